// File: rtl/bit_shifter.sv
// Serial single-bit delay line with two independent fixed taps.
// out1 carries data delayed DELAY1 clocks, out2 carries data delayed DELAY2 clocks.
module bit_shifter #(
    parameter int unsigned DELAY1 = 3,
    parameter int unsigned DELAY2 = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic out1,
    output logic out2
);

    localparam int unsigned MAX_DELAY = 64;

    // Clamp only so an illegal instance still elaborates far enough to report the error
    localparam int unsigned D1 = (DELAY1 >= 1 && DELAY1 <= MAX_DELAY) ? DELAY1 : 1;
    localparam int unsigned D2 = (DELAY2 >= 1 && DELAY2 <= MAX_DELAY) ? DELAY2 : 1;
    localparam int unsigned L  = (D1 > D2) ? D1 : D2;
    localparam int unsigned T1 = D1 - 1;
    localparam int unsigned T2 = D2 - 1;

    if (DELAY1 == 0 || DELAY1 > MAX_DELAY) begin : g_bad_delay1
        $error("bit_shifter: DELAY1=%0d outside legal range 1..64", DELAY1);
    end

    if (DELAY2 == 0 || DELAY2 > MAX_DELAY) begin : g_bad_delay2
        $error("bit_shifter: DELAY2=%0d outside legal range 1..64", DELAY2);
    end

    logic [L-1:0] r_sr;
    logic [L-1:0] w_sr_next;

    if (L == 1) begin : g_len_one
        assign w_sr_next = data;
    end else begin : g_len_many
        assign w_sr_next = {r_sr[L-2:0], data};
    end

    // Shift every cycle; reset clears all in-flight bits immediately
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sr <= '0;
        end else begin
            r_sr <= w_sr_next;
        end
    end

    assign out1 = r_sr[T1];
    assign out2 = r_sr[T2];

endmodule

// File: tb/tb_bit_shifter.sv
// Scoreboard bench for bit_shifter: four tap configurations share one input stream.
module tb_bit_shifter;

    localparam int NOUT = 8;
    localparam int DLY [NOUT] = '{3, 5, 4, 4, 5, 2, 1, 64};

    logic clk;
    logic rst;
    logic data;
    logic [NOUT-1:0] outs;

    int n_chk;
    int n_fail;

    logic            hist [$];
    logic [NOUT-1:0] exp_q [$];

    bit_shifter #(3, 5) u_a (
        .clk(clk), .rst(rst), .data(data), .out1(outs[0]), .out2(outs[1])
    );
    bit_shifter #(4, 4) u_b (
        .clk(clk), .rst(rst), .data(data), .out1(outs[2]), .out2(outs[3])
    );
    bit_shifter #(5, 2) u_c (
        .clk(clk), .rst(rst), .data(data), .out1(outs[4]), .out2(outs[5])
    );
    bit_shifter #(1, 64) u_d (
        .clk(clk), .rst(rst), .data(data), .out1(outs[6]), .out2(outs[7])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int idx, input logic act, input logic want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s[%0d] (delay %0d) at %0t: got %b expected %b",
                     name, idx, DLY[idx], $time, act, want);
        end
    endtask

    // Expected outputs after the coming edge, from the bench's own history of samples
    function automatic logic [NOUT-1:0] model();
        logic [NOUT-1:0] e;
        for (int i = 0; i < NOUT; i++) begin
            e[i] = (hist.size() >= DLY[i]) ? hist[DLY[i]-1] : 1'b0;
        end
        return e;
    endfunction

    // One clock of stimulus: drive at negedge, push expectation, return at the posedge
    task automatic cycle(input logic v, input logic r);
        @(negedge clk);
        data = v;
        rst  = r;
        if (!r) begin
            hist.delete();
        end else begin
            hist.push_front(v);
            if (hist.size() > 64) void'(hist.pop_back());
        end
        exp_q.push_back(model());
        if (!r) begin
            #1;
            for (int i = 0; i < NOUT; i++) chk("async_rst", i, outs[i], 1'b0);
        end
        @(posedge clk);
    endtask

    // Monitor: outputs are presented every cycle, compare just after each edge
    initial begin
        logic [NOUT-1:0] e;
        forever begin
            @(posedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int i = 0; i < NOUT; i++) chk("stream", i, outs[i], e[i]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p1;
        logic [7:0] p2;
        logic [3:0] rec;
        n_chk  = 0;
        n_fail = 0;
        rst    = 1'b0;
        data   = 1'b0;

        #1;
        for (int i = 0; i < NOUT; i++) chk("por", i, outs[i], 1'b0);

        // Reset held with toggling data
        for (int k = 0; k < 10; k++) cycle(k[0] ? 1'b1 : 1'b0, 1'b0);

        // Single pulse sampled at edge 0; hand-derived tap windows for #(3,5)
        p1 = 8'b0000_0100;
        p2 = 8'b0001_0000;
        for (int j = 0; j < 8; j++) begin
            cycle((j == 0) ? 1'b1 : 1'b0, 1'b1);
            #3;
            chk("pulse_out1", 0, outs[0], p1[j]);
            chk("pulse_out2", 1, outs[1], p2[j]);
            chk("pulse_min", 6, outs[6], (j == 0) ? 1'b1 : 1'b0);
        end

        // All-ones stream long enough to fill the 64 tap
        for (int k = 0; k < 70; k++) cycle(1'b1, 1'b1);
        #3;
        chk("ones_max", 7, outs[7], 1'b1);

        // One-cycle reset pulse mid-stream, then recovery with data held high
        cycle(1'b1, 1'b0);
        rec = 4'b1000;
        for (int j = 1; j <= 3; j++) begin
            cycle(1'b1, 1'b1);
            #3;
            chk("recover_out1", 0, outs[0], rec[j]);
        end

        // Random stream
        for (int k = 0; k < 200; k++) cycle(1'($urandom_range(0, 1)), 1'b1);

        // Mid-stream async reset after random data, then release
        cycle(1'b1, 1'b0);
        for (int k = 0; k < 6; k++) cycle(1'($urandom_range(0, 1)), 1'b1);

        @(posedge clk);
        #3;
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
